// File: rtl/byte_serializer_pkg.sv
// byte_serializer_pkg: shared byte width and serializer FSM encoding
package byte_serializer_pkg;
    localparam int BYTE_W = 8;
    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;
endpackage

// File: rtl/byte_serializer_if.sv
// byte_serializer_if: upstream byte valid/ready handshake
interface byte_serializer_if;
    import byte_serializer_pkg::*;
    logic              byte_valid;
    logic [BYTE_W-1:0] byte_in;
    logic              byte_ready;
    modport master (output byte_valid, byte_in, input byte_ready);
    modport slave (input byte_valid, byte_in, output byte_ready);
endinterface

// File: rtl/byte_fifo.sv
// byte_fifo: show-ahead byte FIFO with occupancy counter and synchronous flush
module byte_fifo
    import byte_serializer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [BYTE_W-1:0] din,
    output logic [BYTE_W-1:0] dout,
    output logic              full,
    output logic              empty
);
    localparam int AW = $clog2(DEPTH);
    logic [BYTE_W-1:0] mem [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;
    assign dout    = mem[rptr_q];
    // pointers wrap naturally since DEPTH is a power of two; flush zeroes everything
    always_comb begin
        wptr_d = flush ? '0 : wptr_q + AW'(do_push);
        rptr_d = flush ? '0 : rptr_q + AW'(do_pop);
        cnt_d  = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
    // valid-tracking state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end
    // storage needs no reset; occupancy decides what is valid
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr_q] <= din;
    end
endmodule

// File: rtl/byte_serializer.sv
// byte_serializer: queues bytes and shifts them out one bit per cycle
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    byte_serializer_if.slave        up,
    output logic                    bit_out,
    output logic                    bit_valid,
    output logic                    frame_start,
    output logic                    busy
);
    state_t            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [BYTE_W-1:0] sh_q, sh_d, dout;
    logic              bit_out_q, bit_out_d, bit_valid_q, bit_valid_d, fs_q, fs_d;
    logic              full, empty, push, pop, last;
    function automatic logic head(input logic [BYTE_W-1:0] b);
        return MSB_FIRST ? b[BYTE_W-1] : b[0];
    endfunction
    function automatic logic [BYTE_W-1:0] adv(input logic [BYTE_W-1:0] b);
        return MSB_FIRST ? {b[BYTE_W-2:0], 1'b0} : {1'b0, b[BYTE_W-1:1]};
    endfunction
    assign last          = state_q == IDLE || cnt_q == 3'd7;
    assign push          = up.byte_valid && !full && !flush;
    assign pop           = !flush && !empty && last;
    assign up.byte_ready = !full;
    assign busy          = state_q == SHIFT || !empty;
    assign bit_out       = bit_out_q;
    assign bit_valid     = bit_valid_q;
    assign frame_start   = fs_q;
    byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (up.byte_in),
        .dout  (dout),
        .full  (full),
        .empty (empty)
    );
    // next state: flush aborts, a pop (re)loads the shifter, otherwise shift or go idle
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + 3'd1;
        sh_d        = adv(sh_q);
        bit_out_d   = head(sh_q);
        bit_valid_d = 1'b1;
        fs_d        = 1'b0;
        if (flush || (last && !pop)) begin
            state_d     = IDLE;
            cnt_d       = '0;
            sh_d        = '0;
            bit_out_d   = 1'b0;
            bit_valid_d = 1'b0;
        end else if (pop) begin
            state_d   = SHIFT;
            cnt_d     = '0;
            sh_d      = adv(dout);
            bit_out_d = head(dout);
            fs_d      = state_q == IDLE;
        end
    end
    // state register and registered serial outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sh_q        <= '0;
            bit_out_q   <= 1'b0;
            bit_valid_q <= 1'b0;
            fs_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sh_q        <= sh_d;
            bit_out_q   <= bit_out_d;
            bit_valid_q <= bit_valid_d;
            fs_q        <= fs_d;
        end
    end
endmodule

// File: tb/tb_byte_serializer.sv
// tb_byte_serializer: randomized and directed checks against a bit-stream model
module tb_byte_serializer;
    import byte_serializer_pkg::*;
    typedef logic bitq_t [$];
    logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
    logic bit_out, bit_valid, frame_start, busy;
    int checks = 0, failures = 0;
    logic obs [$];
    int fs_cnt = 0, runs = 0, idle_bad = 0;
    logic prev_valid = 1'b0;
    byte_serializer_if bus ();
    byte_serializer #(.DEPTH(4), .MSB_FIRST(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .up          (bus),
        .bit_out     (bit_out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .busy        (busy)
    );
    always #5 clk = ~clk;
    // monitor collects the serial stream mid-cycle
    always @(negedge clk) begin
        if (bit_valid) obs.push_back(bit_out);
        if (!bit_valid && bit_out) idle_bad <= idle_bad + 1;
        if (frame_start) fs_cnt <= fs_cnt + 1;
        if (bit_valid && !prev_valid) runs <= runs + 1;
        prev_valid <= bit_valid;
    end
    // reference: each byte contributes its 8 bits, most significant first
    function automatic bitq_t serial_bits(input logic [7:0] bytes [$]);
        bitq_t q;
        foreach (bytes[j]) for (int i = 0; i < 8; i++) q.push_back(bytes[j][7-i]);
        return q;
    endfunction
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic wait_idle(input int lim);
        int n = 0;
        while ((busy || bit_valid) && n < lim) begin
            tick();
            n++;
        end
        checks++;
        if (busy || bit_valid) begin
            failures++;
            $display("FAIL wait_idle timeout busy=%0b bit_valid=%0b exp=0", busy, bit_valid);
        end
    endtask
    task automatic test_reset();
        tick();
        checks++;
        if ({bit_out, bit_valid, frame_start, busy, bus.byte_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=00001", {bit_out, bit_valid, frame_start, busy, bus.byte_ready});
        end
        rst_n = 1'b1;
        tick();
    endtask
    task automatic test_single_a5();
        logic [7:0] a = 8'hA5;
        bus.byte_valid = 1'b1;
        bus.byte_in = a;
        tick();
        bus.byte_valid = 1'b0;
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL a5_latency bit_valid=%0b busy=%0b exp=0,1", bit_valid, busy);
        end
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({bit_valid, bit_out, frame_start} !== {1'b1, a[7-i], i == 0}) begin
                failures++;
                $display("FAIL a5_bit%0d got=%b exp=%b", i, {bit_valid, bit_out, frame_start}, {1'b1, a[7-i], i == 0});
            end
        end
        tick();
        checks++;
        if (bit_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL a5_end bit_valid=%0b busy=%0b exp=0,0", bit_valid, busy);
        end
    endtask
    task automatic test_back_to_back();
        logic [7:0] src [$] = '{8'h3C, 8'hF0};
        bitq_t exp = serial_bits(src);
        int ob = obs.size(), fb = fs_cnt, rb = runs;
        foreach (src[j]) begin
            bus.byte_valid = 1'b1;
            bus.byte_in = src[j];
            tick();
        end
        bus.byte_valid = 1'b0;
        wait_idle(40);
        checks++;
        if (obs.size() - ob != 16 || fs_cnt - fb != 1 || runs - rb != 1) begin
            failures++;
            $display("FAIL b2b_shape bits=%0d starts=%0d runs=%0d exp=16,1,1", obs.size() - ob, fs_cnt - fb, runs - rb);
        end
        for (int i = 0; i < 16 && ob + i < obs.size(); i++) begin
            checks++;
            if (obs[ob+i] !== exp[i]) begin
                failures++;
                $display("FAIL b2b_bit%0d got=%0b exp=%0b", i, obs[ob+i], exp[i]);
            end
        end
    endtask
    task automatic test_fill();
        logic [7:0] sent [$];
        bitq_t exp;
        int ob = obs.size(), k = 1, n = 0;
        logic saw_full = 1'b0, take;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h01;
        while (k <= 6 && n < 100) begin
            take = bus.byte_ready;
            if (!take) saw_full = 1'b1;
            if (take) sent.push_back(bus.byte_in);
            tick();
            n++;
            if (take) begin
                k++;
                bus.byte_in = 8'(k);
            end
        end
        bus.byte_valid = 1'b0;
        wait_idle(100);
        exp = serial_bits('{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
        checks++;
        if (saw_full !== 1'b1 || sent.size() != 6) begin
            failures++;
            $display("FAIL fill_ready saw_full=%0b accepted=%0d exp=1,6", saw_full, sent.size());
        end
        checks++;
        if (obs.size() - ob != 48) begin
            failures++;
            $display("FAIL fill_count bits=%0d exp=48", obs.size() - ob);
        end
        for (int i = 0; i < 48 && ob + i < obs.size(); i++) begin
            checks++;
            if (obs[ob+i] !== exp[i]) begin
                failures++;
                $display("FAIL fill_bit%0d got=%0b exp=%0b", i, obs[ob+i], exp[i]);
            end
        end
    endtask
    task automatic test_flush();
        int ob;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'hFF;
        tick();
        bus.byte_in = 8'($urandom);
        tick();
        bus.byte_in = 8'($urandom);
        tick();
        bus.byte_valid = 1'b0;
        tick();
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b1) begin
            failures++;
            $display("FAIL flush_third_bit got=%0b%0b exp=11", bit_valid, bit_out);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if ({bit_valid, bit_out, frame_start, busy, bus.byte_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL flush_state got=%b exp=00001", {bit_valid, bit_out, frame_start, busy, bus.byte_ready});
        end
        ob = obs.size();
        repeat (20) tick();
        checks++;
        if (obs.size() != ob) begin
            failures++;
            $display("FAIL flush_silence extra_bits=%0d exp=0", obs.size() - ob);
        end
    endtask
    task automatic test_reset_mid();
        bitq_t exp = serial_bits('{8'h0F});
        int ob;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h81;
        tick();
        bus.byte_valid = 1'b0;
        repeat (5) tick();
        checks++;
        if (bit_valid !== 1'b1 || bit_out !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_fifth got=%0b%0b%0b exp=101", bit_valid, bit_out, busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bit_out, bit_valid, frame_start, busy, bus.byte_ready} !== 5'b00001) begin
            failures++;
            $display("FAIL rstmid_async got=%b exp=00001", {bit_out, bit_valid, frame_start, busy, bus.byte_ready});
        end
        tick();
        rst_n = 1'b1;
        tick();
        ob = obs.size();
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h0F;
        tick();
        bus.byte_valid = 1'b0;
        wait_idle(40);
        checks++;
        if (obs.size() - ob != 8) begin
            failures++;
            $display("FAIL rstmid_count bits=%0d exp=8", obs.size() - ob);
        end
        for (int i = 0; i < 8 && ob + i < obs.size(); i++) begin
            checks++;
            if (obs[ob+i] !== exp[i]) begin
                failures++;
                $display("FAIL rstmid_bit%0d got=%0b exp=%0b", i, obs[ob+i], exp[i]);
            end
        end
    endtask
    task automatic test_detect();
        logic [7:0] w = '0;
        int ob = obs.size(), hit = -1;
        bus.byte_valid = 1'b1;
        bus.byte_in = 8'h12;
        tick();
        bus.byte_in = 8'hA5;
        tick();
        bus.byte_valid = 1'b0;
        wait_idle(40);
        for (int i = 0; ob + i < obs.size(); i++) begin
            w = {w[6:0], obs[ob+i]};
            if (i >= 7 && w == 8'hA5 && hit < 0) hit = i;
        end
        checks++;
        if (hit != 15) begin
            failures++;
            $display("FAIL detect_a5 match_at=%0d exp=15", hit);
        end
    endtask
    task automatic test_random();
        logic [7:0] sent [$];
        bitq_t exp;
        int ob = obs.size();
        for (int c = 0; c < 300; c++) begin
            bus.byte_valid = ($urandom_range(0, 2) != 0);
            bus.byte_in = 8'($urandom);
            if (bus.byte_valid && bus.byte_ready) sent.push_back(bus.byte_in);
            tick();
        end
        bus.byte_valid = 1'b0;
        wait_idle(200);
        exp = serial_bits(sent);
        checks++;
        if (obs.size() - ob != exp.size()) begin
            failures++;
            $display("FAIL rand_count bits=%0d exp=%0d", obs.size() - ob, exp.size());
        end
        for (int i = 0; i < exp.size() && ob + i < obs.size(); i++) begin
            checks++;
            if (obs[ob+i] !== exp[i]) begin
                failures++;
                $display("FAIL rand_bit%0d got=%0b exp=%0b", i, obs[ob+i], exp[i]);
            end
        end
    endtask
    task automatic test_idle_zero();
        checks++;
        if (idle_bad != 0) begin
            failures++;
            $display("FAIL idle_bit_out cycles_high=%0d exp=0", idle_bad);
        end
    endtask
    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in = '0;
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_fill();
        test_flush();
        test_reset_mid();
        test_detect();
        test_random();
        test_idle_zero();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
